// File: rtl/frogg_collision_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frogg_collision_ctrl
// Brief    : Per-frame hit/goal judge that keeps lives and score and asks
//            the frog controller to respawn the frog.
// Revision : 1.0 - initial release
// ============================================================================
module frogg_collision_ctrl #(
    parameter int c_LIVES      = 3,
    parameter int c_SCORE_W    = 8,
    parameter int c_HIT_FRAMES = 60,
    parameter int c_WIN_FRAMES = 30,
    parameter int c_GOAL_Y     = 0
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Start,
    input  logic                 i_Frame_End,
    input  logic                 i_Draw_Frog,
    input  logic                 i_Draw_Car,
    input  logic [9:0]           i_Frog_Y,
    output logic                 o_Frog_Reset,
    output logic [2:0]           o_Lives,
    output logic [c_SCORE_W-1:0] o_Score,
    output logic                 o_Game_Active,
    output logic                 o_Game_Over,
    output logic [2:0]           o_State
);

    localparam int c_MAX_FRAMES = (c_HIT_FRAMES > c_WIN_FRAMES) ? c_HIT_FRAMES : c_WIN_FRAMES;
    localparam int c_CNT_W      = $clog2(c_MAX_FRAMES + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_HIT  = 3'd2,
        ST_WIN  = 3'd3,
        ST_OVER = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [2:0]           r_lives, w_lives_nxt;
    logic [c_SCORE_W-1:0] r_score, w_score_nxt;
    logic [c_CNT_W-1:0]   r_frame_cnt, w_frame_cnt_nxt;
    logic                 r_hit, w_hit_nxt;
    logic                 w_respawn;
    logic                 w_hit_frame;
    logic                 w_at_goal;

    // A same-cycle overlap on the frame-end pulse still counts as a hit.
    assign w_hit_frame = r_hit | (i_Draw_Frog & i_Draw_Car);
    assign w_at_goal   = (i_Frog_Y == 10'(c_GOAL_Y));

    always_comb begin
        w_state_nxt     = r_state;
        w_lives_nxt     = r_lives;
        w_score_nxt     = r_score;
        w_frame_cnt_nxt = r_frame_cnt;
        w_hit_nxt       = 1'b0;
        w_respawn       = 1'b0;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (i_Start) begin
                    w_state_nxt = ST_PLAY;
                    w_lives_nxt = 3'(c_LIVES);
                    w_score_nxt = '0;
                    w_respawn   = 1'b1;
                end
            end
            ST_PLAY: begin
                if (i_Frame_End) begin
                    if (w_hit_frame) begin
                        w_state_nxt = ST_HIT;
                        w_lives_nxt = (r_lives != 3'd0) ? r_lives - 3'd1 : 3'd0;
                    end else if (w_at_goal) begin
                        w_state_nxt = ST_WIN;
                        w_score_nxt = (&r_score) ? r_score : r_score + c_SCORE_W'(1);
                    end
                end else begin
                    w_hit_nxt = w_hit_frame;
                end
            end
            ST_HIT: begin
                if (i_Frame_End) begin
                    if (r_frame_cnt == c_CNT_W'(c_HIT_FRAMES - 1)) begin
                        if (r_lives == 3'd0) begin
                            w_state_nxt = ST_OVER;
                        end else begin
                            w_state_nxt = ST_PLAY;
                            w_respawn   = 1'b1;
                        end
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + c_CNT_W'(1);
                    end
                end
            end
            ST_WIN: begin
                if (i_Frame_End) begin
                    if (r_frame_cnt == c_CNT_W'(c_WIN_FRAMES - 1)) begin
                        w_state_nxt = ST_PLAY;
                        w_respawn   = 1'b1;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + c_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_state_nxt != r_state) begin
            w_frame_cnt_nxt = '0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state       <= ST_IDLE;
            r_lives       <= 3'(c_LIVES);
            r_score       <= '0;
            r_frame_cnt   <= '0;
            r_hit         <= 1'b0;
            o_Frog_Reset  <= 1'b0;
            o_Game_Active <= 1'b0;
            o_Game_Over   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lives       <= w_lives_nxt;
            r_score       <= w_score_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_hit         <= w_hit_nxt;
            o_Frog_Reset  <= w_respawn;
            o_Game_Active <= (w_state_nxt == ST_PLAY);
            o_Game_Over   <= (w_state_nxt == ST_OVER);
        end
    end

    assign o_State = r_state;
    assign o_Lives = r_lives;
    assign o_Score = r_score;

endmodule
`default_nettype wire

// File: tb/tb_frogg_collision_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frogg_collision_ctrl
// Brief    : Vector table, directed corner sequences and random play checked
//            against a frame-level game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frogg_collision_ctrl;

    localparam int c_LIVES = 3;
    localparam int c_SMAX  = 255;
    localparam int c_HOLDH = 60;
    localparam int c_HOLDW = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       frame_end = 1'b0;
    logic       draw_frog = 1'b0;
    logic       draw_car = 1'b0;
    logic [9:0] frog_y = 10'd100;
    logic       frog_reset;
    logic [2:0] lives;
    logic [7:0] score;
    logic       game_active;
    logic       game_over;
    logic [2:0] state;

    int n_total = 0;
    int n_pass  = 0;

    // Game model: phase name, lives, score, whether this frame has a hit,
    // frames already spent in a hold, and the pending respawn pulse.
    int m_phase = 0;
    int m_lives = c_LIVES;
    int m_score = 0;
    bit m_hit   = 1'b0;
    int m_held  = 0;
    bit m_resp  = 1'b0;

    frogg_collision_ctrl dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Start      (start),
        .i_Frame_End  (frame_end),
        .i_Draw_Frog  (draw_frog),
        .i_Draw_Car   (draw_car),
        .i_Frog_Y     (frog_y),
        .o_Frog_Reset (frog_reset),
        .o_Lives      (lives),
        .o_Score      (score),
        .o_Game_Active(game_active),
        .o_Game_Over  (game_over),
        .o_State      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_step(input bit r, s, f, d1, d2, input int y);
        m_resp = 1'b0;
        if (r) begin
            m_phase = 0; m_lives = c_LIVES; m_score = 0; m_hit = 1'b0; m_held = 0;
        end else if (m_phase == 0 || m_phase == 4) begin
            if (s) begin
                m_phase = 1; m_lives = c_LIVES; m_score = 0; m_resp = 1'b1;
            end
        end else if (m_phase == 1) begin
            m_hit = m_hit | (d1 & d2);
            if (f) begin
                if (m_hit) begin
                    m_phase = 2; m_held = 0;
                    if (m_lives > 0) m_lives = m_lives - 1;
                end else if (y == 0) begin
                    m_phase = 3; m_held = 0;
                    if (m_score < c_SMAX) m_score = m_score + 1;
                end
                m_hit = 1'b0;
            end
        end else if (f) begin
            m_held = m_held + 1;
            if (m_phase == 2 && m_held == c_HOLDH) begin
                m_phase = (m_lives == 0) ? 4 : 1;
                m_resp  = (m_lives != 0);
            end else if (m_phase == 3 && m_held == c_HOLDW) begin
                m_phase = 1; m_resp = 1'b1;
            end
        end
    endtask

    task automatic drive(input bit r, s, f, d1, d2, input logic [9:0] y);
        int exp_v, act_v;
        rst = r; start = s; frame_end = f; draw_frog = d1; draw_car = d2; frog_y = y;
        model_step(r, s, f, d1, d2, int'(y));
        @(posedge clk);
        #1;
        exp_v = {m_phase[2:0], m_lives[2:0], m_score[7:0], m_resp, m_phase == 1, m_phase == 4};
        act_v = {state, lives, score, frog_reset, game_active, game_over};
        chk("model", act_v, exp_v);
    endtask

    task automatic frames(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd100);
    endtask

    task automatic expect_out(input string name, input int st, lv, sc, fr);
        chk({name, ".state"}, int'(state), st);
        chk({name, ".lives"}, int'(lives), lv);
        chk({name, ".score"}, int'(score), sc);
        chk({name, ".frog_reset"}, int'(frog_reset), fr);
    endtask

    typedef struct {
        bit         r, s, f, d1, d2;
        logic [9:0] y;
        int         e_st, e_lv, e_sc, e_fr;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd100, 0, 3, 0, 0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   0, 3, 0, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 1, 3, 0, 1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd100, 1, 3, 0, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd100, 1, 3, 0, 0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd100, 1, 3, 0, 0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd100, 2, 2, 0, 0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd100, 2, 2, 0, 0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 2, 2, 0, 0};

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].r, vecs[i].s, vecs[i].f, vecs[i].d1, vecs[i].d2, vecs[i].y);
            expect_out($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_lv, vecs[i].e_sc, vecs[i].e_fr);
        end

        // Hit hold: one frame already counted above.
        frames(58);
        expect_out("hit_hold59", 2, 2, 0, 0);
        frames(1);
        expect_out("hit_resume", 1, 2, 0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd100);
        expect_out("hit_pulse_end", 1, 2, 0, 0);

        // Reaching the goal.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
        expect_out("win_enter", 3, 2, 1, 0);
        frames(29);
        expect_out("win_hold29", 3, 2, 1, 0);
        frames(1);
        expect_out("win_resume", 1, 2, 1, 1);

        // Overlap and goal in the same frame-end cycle.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0);
        expect_out("hit_and_goal", 2, 1, 1, 0);
        frames(60);
        expect_out("hit2_resume", 1, 1, 1, 1);

        // Third hit runs out of lives.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd100);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd100);
        expect_out("hit3", 2, 0, 1, 0);
        frames(59);
        expect_out("hit3_hold59", 2, 0, 1, 0);
        frames(1);
        expect_out("game_over", 4, 0, 1, 0);
        chk("game_over.flag", int'(game_over), 1);
        chk("game_over.active", int'(game_active), 0);
        frames(3);
        expect_out("game_over_held", 4, 0, 1, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd100);
        expect_out("restart", 1, 3, 0, 1);
        chk("restart.active", int'(game_active), 1);

        // Reset during a hit hold at frame 10.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd100);
        expect_out("hit4", 2, 2, 0, 0);
        frames(10);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd100);
        expect_out("mid_reset", 0, 3, 0, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0);
        expect_out("idle_frame_end", 0, 3, 0, 0);

        // Score saturation.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd100);
        repeat (c_SMAX) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
            frames(30);
        end
        expect_out("score_full", 1, 3, 255, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
        expect_out("score_sat", 3, 3, 255, 0);

        // Random play against the model.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd100);
        for (int i = 0; i < 6000; i++) begin
            drive(($urandom_range(0, 399) == 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 1023)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
